// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register: load/clear/hold, logical/arithmetic shifts and rotates
// Multi-position shifts step one bit per enabled clock under a start/busy/done handshake.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       sel,
  input  logic [AW-1:0]    amt,
  input  logic [WIDTH-1:0] di,
  input  logic             si,
  output logic [WIDTH-1:0] so,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_SLL   = 3'b001;
  localparam logic [2:0] OP_SRL   = 3'b010;
  localparam logic [2:0] OP_SRA   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_LOAD  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] so_d;
  logic             sout_d;
  logic             done_d;
  logic [WIDTH:0]   step_res;
  logic             is_shift;

  // One bit-step of a shift/rotate; result is {bit shifted out, new register}.
  function automatic logic [WIDTH:0] shift_step(input logic [2:0] op,
                                                input logic [WIDTH-1:0] v,
                                                input logic fill);
    logic [WIDTH:0] r;
    case (op)
      OP_SLL:  r = {v[WIDTH-1], v[WIDTH-2:0], fill};
      OP_SRL:  r = {v[0], fill, v[WIDTH-1:1]};
      OP_SRA:  r = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      OP_ROL:  r = {v[WIDTH-1], v[WIDTH-2:0], v[WIDTH-1]};
      OP_ROR:  r = {v[0], v[0], v[WIDTH-1:1]};
      default: r = {1'b0, v};
    endcase
    return r;
  endfunction

  assign is_shift = (sel != OP_HOLD) && (sel != OP_LOAD) && (sel != OP_CLEAR);
  assign step_res = shift_step(op_q, so, fill_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    fill_d  = fill_q;
    so_d    = so;
    sout_d  = sout;
    done_d  = 1'b0;
    if (en) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_shift && (amt != '0)) begin
              op_d    = sel;
              fill_d  = si;
              cnt_d   = amt;
              state_d = S_RUN;
            end else begin
              done_d = 1'b1;
              if (sel == OP_LOAD) begin
                so_d   = di;
                sout_d = 1'b0;
              end else if (sel == OP_CLEAR) begin
                so_d   = '0;
                sout_d = 1'b0;
              end
            end
          end
        end
        S_RUN: begin
          so_d   = step_res[WIDTH-1:0];
          sout_d = step_res[WIDTH];
          cnt_d  = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= OP_HOLD;
      fill_q  <= 1'b0;
      so      <= '0;
      sout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      so      <= so_d;
      sout    <= sout_d;
      done    <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);

endmodule
